rob_tid_alloc: RTL

- Front end of the read path, sitting ahead of the tag-compare stage; the ROB that reorders hit/miss responses is the far end.
- Accepts AXI read-address (AR) requests.
- Assigns each request a sequential transaction ID (tID), records the AXI ARID for that tID, and forwards {tID, addr} downstream.
- The ROB retires tIDs strictly in order; on each retire this block frees the entry and returns the original ARID for use as RID.

---
 rtl/rob_tid_alloc_pkg.sv | 29 ++
 rtl/rob_tid_alloc_if.sv | 31 +++
 rtl/rob_tid_alloc_rid_table.sv | 24 ++
 rtl/rob_tid_alloc.sv | 94 +++++++++
 4 files changed

// File: rtl/rob_tid_alloc_pkg.sv
// Shared tID constants and request types for the read-path front end and the ROB.
// The ROB's expected-tID counter uses the same TID_WIDTH/TID_MAX.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 8
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

package rob_tid_alloc_pkg;
  localparam int ID_WIDTH   = `AXI_ID_WIDTH;
  localparam int ADDR_WIDTH = `AXI_ADDR_WIDTH;
  localparam int TID_WIDTH  = 4;
  localparam int TID_MAX    = 2**TID_WIDTH;

  typedef logic [TID_WIDTH-1:0]  tid_t;
  typedef logic [TID_WIDTH:0]    cnt_t;
  typedef logic [ID_WIDTH-1:0]   id_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    tid_t  tid;
    addr_t addr;
  } rd_req_t;

  function automatic tid_t tid_inc(input tid_t t);
    return t + tid_t'(1);
  endfunction
endpackage

// File: rtl/rob_tid_alloc_if.sv
// AR, downstream request and ROB retire signals of the tID allocator.
// slave = allocator side, master = requester/ROB side.
interface rob_tid_alloc_if;
  import rob_tid_alloc_pkg::*;

  logic  arvalid_i;
  logic  arready_o;
  id_t   arid_i;
  addr_t araddr_i;
  logic  req_valid_o;
  logic  req_ready_i;
  tid_t  req_tid_o;
  addr_t req_addr_o;
  logic  retire_i;
  tid_t  retire_tid_i;
  id_t   retire_rid_o;
  cnt_t  outstanding_o;
  logic  err_o;

  modport slave (
    input  arvalid_i, arid_i, araddr_i, req_ready_i, retire_i, retire_tid_i,
    output arready_o, req_valid_o, req_tid_o, req_addr_o, retire_rid_o,
           outstanding_o, err_o
  );

  modport master (
    output arvalid_i, arid_i, araddr_i, req_ready_i, retire_i, retire_tid_i,
    input  arready_o, req_valid_o, req_tid_o, req_addr_o, retire_rid_o,
           outstanding_o, err_o
  );
endinterface

// File: rtl/rob_tid_alloc_rid_table.sv
// tID-indexed ARID store: one synchronous write port, one asynchronous read port.
// Contents are not reset; an entry is only read after its tID has been allocated.
module rob_tid_alloc_rid_table
  import rob_tid_alloc_pkg::*;
(
  input  logic clk,
  input  logic i_we,
  input  tid_t i_waddr,
  input  id_t  i_wdata,
  input  tid_t i_raddr,
  output id_t  o_rdata
);

  id_t r_mem [TID_MAX];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rob_tid_alloc.sv
// Tags AR requests with sequential tIDs, forwards {tID, addr} one cycle later, returns ARID on in-order retire.
// Single output register at full throughput; arready drops when 16 tIDs are outstanding or the output is stalled.
module rob_tid_alloc
  import rob_tid_alloc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  rob_tid_alloc_if.slave bus
);

  logic    r_rdy_en;
  tid_t    r_alloc_ptr;
  tid_t    r_retire_ptr;
  cnt_t    r_count;
  cnt_t    w_count_nxt;
  rd_req_t r_req;
  logic    r_req_vld;
  logic    r_err;

  logic    w_full;
  logic    w_arready;
  logic    w_ar_hs;
  logic    w_req_hs;
  logic    w_ret_ok;
  logic    w_ret_bad;
  id_t     w_rid;

  // Count is one bit wider than a tID, so its MSB alone means "all 16 in flight".
  assign w_full    = r_count[TID_WIDTH];
  assign w_arready = r_rdy_en && !w_full && (!r_req_vld || bus.req_ready_i);
  assign w_ar_hs   = bus.arvalid_i && w_arready;
  assign w_req_hs  = r_req_vld && bus.req_ready_i;
  assign w_ret_ok  = bus.retire_i && (r_count != '0) && (bus.retire_tid_i == r_retire_ptr);
  assign w_ret_bad = bus.retire_i && !w_ret_ok;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_ar_hs, w_ret_ok})
      2'b10:   w_count_nxt = r_count + cnt_t'(1);
      2'b01:   w_count_nxt = r_count - cnt_t'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en     <= 1'b0;
      r_alloc_ptr  <= '0;
      r_retire_ptr <= '0;
      r_count      <= '0;
      r_req        <= '0;
      r_req_vld    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_count  <= w_count_nxt;
      if (w_ar_hs) begin
        r_alloc_ptr <= tid_inc(r_alloc_ptr);
      end
      if (w_ret_ok) begin
        r_retire_ptr <= tid_inc(r_retire_ptr);
      end
      if (w_ret_bad) begin
        r_err <= 1'b1;
      end
      // A new accept overwrites the output register; it is only possible when it is empty or draining.
      if (w_ar_hs) begin
        r_req.tid  <= r_alloc_ptr;
        r_req.addr <= bus.araddr_i;
        r_req_vld  <= 1'b1;
      end else if (w_req_hs) begin
        r_req_vld  <= 1'b0;
      end
    end
  end

  rob_tid_alloc_rid_table u_rid_table (
    .clk     (clk),
    .i_we    (w_ar_hs),
    .i_waddr (r_alloc_ptr),
    .i_wdata (bus.arid_i),
    .i_raddr (bus.retire_tid_i),
    .o_rdata (w_rid)
  );

  assign bus.arready_o     = w_arready;
  assign bus.req_valid_o   = r_req_vld;
  assign bus.req_tid_o     = r_req.tid;
  assign bus.req_addr_o    = r_req.addr;
  assign bus.retire_rid_o  = w_rid;
  assign bus.outstanding_o = r_count;
  assign bus.err_o         = r_err;

endmodule
